// File: rtl/tile_map_renderer_pkg.sv
// Shared constants for the tile map renderer: cell codes, colours and grid geometry.
package tile_map_renderer_pkg;

   localparam int COLS         = 20;
   localparam int ROWS         = 15;
   localparam int CELL_LOG2    = 5;
   localparam int ROBOT_MARGIN = 4;

   typedef enum logic [1:0] {
      CELL_EMPTY = 2'd0,
      CELL_WALL  = 2'd1,
      CELL_DIRT  = 2'd2,
      CELL_ROBOT = 2'd3
   } cell_code_e;

   localparam logic [2:0] RGB_BLACK  = 3'b000;
   localparam logic [2:0] RGB_BLUE   = 3'b001;
   localparam logic [2:0] RGB_YELLOW = 3'b110;
   localparam logic [2:0] RGB_RED    = 3'b100;
   localparam logic [2:0] RGB_WHITE  = 3'b111;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_CLEAR = 1'b1
   } wr_state_e;

endpackage

// File: rtl/tile_map_ram.sv
// Simple dual-port cell map RAM: one write port, one registered read port.
// A read colliding with a write to the same address returns the old contents.
module tile_map_ram #(
   parameter int DEPTH  = 300,
   parameter int ADDR_W = 9,
   parameter int DATA_W = 2
) (
   input  logic              clk,
   input  logic              we,
   input  logic [ADDR_W-1:0] waddr,
   input  logic [DATA_W-1:0] wdata,
   input  logic              re,
   input  logic [ADDR_W-1:0] raddr,
   output logic [DATA_W-1:0] rdata
);

   logic [DATA_W-1:0] mem [DEPTH];
   logic [DATA_W-1:0] rdata_q;

   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
      if (re) begin
         rdata_q <= mem[raddr];
      end
   end

   assign rdata = rdata_q;

endmodule

// File: rtl/tile_map_renderer.sv
// Tile map pixel generator: map RAM with write/clear FSM, a two-tick render
// pipeline producing 3-bit RGB, and a frame-counting robot blink timer.
module tile_map_renderer
   import tile_map_renderer_pkg::*;
#(
   parameter int COLS       = tile_map_renderer_pkg::COLS,
   parameter int ROWS       = tile_map_renderer_pkg::ROWS,
   parameter int CELL_LOG2  = tile_map_renderer_pkg::CELL_LOG2,
   parameter int BLINK_LOG2 = 5,
   parameter bit GRID_LINES = 1'b1
) (
   input  logic       CLOCK_50,
   input  logic       reset,
   input  logic       p_tick,
   input  logic       video_on,
   input  logic [9:0] pix_x,
   input  logic [9:0] pix_y,
   input  logic       wr_en,
   input  logic [4:0] wr_col,
   input  logic [3:0] wr_row,
   input  logic [1:0] wr_data,
   output logic       wr_ack,
   input  logic       clear,
   output logic       busy,
   output logic [2:0] graph_rgb,
   output logic       video_on_d
);

   localparam int CELLS   = COLS * ROWS;
   localparam int ADDR_W  = $clog2(CELLS);
   localparam int CELL_PX = 1 << CELL_LOG2;
   localparam int BW      = BLINK_LOG2 + 1;

   wr_state_e             state_q, state_d;
   logic [ADDR_W-1:0]     cnt_q, cnt_d;
   logic                  wr_ack_q, wr_ack_d;
   logic                  ram_we;
   logic [ADDR_W-1:0]     ram_waddr;
   logic [1:0]            ram_wdata;

   logic [9:0]            cell_col, cell_row;
   logic                  in_range;
   logic                  rd_en;
   logic [ADDR_W-1:0]     rd_addr;
   logic [1:0]            rd_data;

   logic                  s1_vid_q, s1_vid_d;
   logic                  s1_in_range_q, s1_in_range_d;
   logic [CELL_LOG2-1:0]  s1_off_x_q, s1_off_x_d;
   logic [CELL_LOG2-1:0]  s1_off_y_q, s1_off_y_d;
   logic [2:0]            rgb_q, rgb_d;
   logic                  vod_q, vod_d;
   logic [BW-1:0]         blink_q, blink_d;
   logic [2:0]            pix_rgb;

   function automatic logic in_body(input logic [CELL_LOG2-1:0] off);
      return (off >= CELL_LOG2'(ROBOT_MARGIN)) &&
             (off <= CELL_LOG2'(CELL_PX - 1 - ROBOT_MARGIN));
   endfunction

   // Write / clear FSM; clear takes priority over a simultaneous write.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      wr_ack_d  = 1'b0;
      ram_we    = 1'b0;
      ram_waddr = cnt_q;
      ram_wdata = CELL_EMPTY;
      case (state_q)
         ST_IDLE: begin
            if (clear) begin
               state_d = ST_CLEAR;
               cnt_d   = '0;
            end else if (wr_en && (wr_col < 5'(COLS)) && (wr_row < 4'(ROWS))) begin
               ram_we    = 1'b1;
               ram_waddr = ADDR_W'(wr_row) * ADDR_W'(COLS) + ADDR_W'(wr_col);
               ram_wdata = wr_data;
               wr_ack_d  = 1'b1;
            end
         end
         ST_CLEAR: begin
            ram_we = 1'b1;
            if (cnt_q == ADDR_W'(CELLS - 1)) begin
               state_d = ST_IDLE;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + ADDR_W'(1);
            end
         end
         default: state_d = ST_CLEAR;
      endcase
      if (reset) begin
         ram_we = 1'b0;
      end
   end

   assign cell_col = pix_x >> CELL_LOG2;
   assign cell_row = pix_y >> CELL_LOG2;
   assign in_range = (cell_col < 10'(COLS)) && (cell_row < 10'(ROWS));
   assign rd_addr  = ADDR_W'(cell_row) * ADDR_W'(COLS) + ADDR_W'(cell_col);
   assign rd_en    = p_tick && in_range;

   tile_map_ram #(
      .DEPTH  (CELLS),
      .ADDR_W (ADDR_W),
      .DATA_W (2)
   ) u_ram (
      .clk   (CLOCK_50),
      .we    (ram_we),
      .waddr (ram_waddr),
      .wdata (ram_wdata),
      .re    (rd_en),
      .raddr (rd_addr),
      .rdata (rd_data)
   );

   // S2 colour decision from the stage-1 latches and the RAM word read at S1.
   always_comb begin
      pix_rgb = RGB_BLACK;
      if (s1_vid_q && s1_in_range_q) begin
         if (GRID_LINES && ((s1_off_x_q == '0) || (s1_off_y_q == '0))) begin
            pix_rgb = RGB_WHITE;
         end else begin
            case (rd_data)
               CELL_WALL:  pix_rgb = RGB_BLUE;
               CELL_DIRT:  pix_rgb = RGB_YELLOW;
               CELL_ROBOT: begin
                  if (in_body(s1_off_x_q) && in_body(s1_off_y_q) && blink_q[BLINK_LOG2]) begin
                     pix_rgb = RGB_RED;
                  end
               end
               default:    pix_rgb = RGB_BLACK;
            endcase
         end
      end
   end

   always_comb begin
      s1_vid_d      = s1_vid_q;
      s1_in_range_d = s1_in_range_q;
      s1_off_x_d    = s1_off_x_q;
      s1_off_y_d    = s1_off_y_q;
      rgb_d         = rgb_q;
      vod_d         = vod_q;
      blink_d       = blink_q;
      if (p_tick) begin
         s1_vid_d      = video_on;
         s1_in_range_d = in_range;
         s1_off_x_d    = pix_x[CELL_LOG2-1:0];
         s1_off_y_d    = pix_y[CELL_LOG2-1:0];
         rgb_d         = pix_rgb;
         vod_d         = s1_vid_q;
         if ((pix_x == '0) && (pix_y == '0)) begin
            blink_d = blink_q + BW'(1);
         end
      end
   end

   always_ff @(posedge CLOCK_50) begin
      if (reset) begin
         state_q       <= ST_CLEAR;
         cnt_q         <= '0;
         wr_ack_q      <= 1'b0;
         s1_vid_q      <= 1'b0;
         s1_in_range_q <= 1'b0;
         s1_off_x_q    <= '0;
         s1_off_y_q    <= '0;
         rgb_q         <= RGB_BLACK;
         vod_q         <= 1'b0;
         blink_q       <= '0;
      end else begin
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         wr_ack_q      <= wr_ack_d;
         s1_vid_q      <= s1_vid_d;
         s1_in_range_q <= s1_in_range_d;
         s1_off_x_q    <= s1_off_x_d;
         s1_off_y_q    <= s1_off_y_d;
         rgb_q         <= rgb_d;
         vod_q         <= vod_d;
         blink_q       <= blink_d;
      end
   end

   assign wr_ack     = wr_ack_q;
   assign busy       = (state_q == ST_CLEAR);
   assign graph_rgb  = rgb_q;
   assign video_on_d = vod_q;

endmodule

// File: doc/tile_map_renderer.md
Name: tile_map_renderer

Overview:
- Pixel-generation stage feeding the VGA top-level RGB register.
- Holds a 20x15 cell map of the pipe environment, 32x32 px per cell on the 640x480 screen.
- Cell codes are written by the robot controller. For each pixel coordinate from the sync generator, the block produces the 3-bit RGB value.
- Replaces the static graphics generator and adds a map RAM, a write/clear port and a blink timer.

Parameters:
- COLS, 20, grid columns.
- ROWS, 15, grid rows.
- CELL_LOG2, 5, log2 of cell size in pixels (32).
- BLINK_LOG2, 5, robot blink half-period = 2^BLINK_LOG2 frames.
- GRID_LINES, 1, when 1, draw grey-free white lines on cell boundaries.

Ports:
- CLOCK_50  in  1  system clock, 50 MHz.
- reset  in  1  synchronous, active-high reset.
- p_tick  in  1  pixel enable, one clock in two.
- video_on  in  1  visible-area flag from the sync generator.
- pix_x  in  10  current pixel column.
- pix_y  in  10  current pixel row.
- wr_en  in  1  cell write request (single-cycle pulse or level).
- wr_col  in  5  target column.
- wr_row  in  4  target row.
- wr_data  in  2  cell code: 0 empty, 1 pipe wall, 2 dirt, 3 robot.
- wr_ack  out  1  one-clock pulse when the write was committed.
- clear  in  1  request to clear the whole map.
- busy  out  1  high during a clear sweep.
- graph_rgb  out  3  {R,G,B}, aligned with video_on_d.
- video_on_d  out  1  video_on delayed to match graph_rgb.

Behaviour:
- Map RAM: COLS*ROWS x 2 bits, address = row*COLS + col (9 bits). One write port and one synchronous read port.
- Read-during-write to the same address returns the old data.
- Render pipeline advances only when p_tick=1. Latency is exactly 2 ticks.
  - S1: latch addr = (pix_y>>CELL_LOG2)*COLS + (pix_x>>CELL_LOG2), the in-cell offsets pix_x[4:0] and pix_y[4:0], and video_on. RAM read issued.
  - S2: RAM data valid. Compute and register graph_rgb; shift video_on into video_on_d.
- The consumer delays hsync/vsync by 2 ticks to compensate for the latency.
- Colour rule, applied in S2 in priority order:
  1. video_on pipeline bit = 0 -> 000.
  2. GRID_LINES=1 and (offset_x==0 or offset_y==0) -> 111.
  3. Code 0 -> 000.
  4. Code 1 -> 001.
  5. Code 2 -> 110.
  6. Code 3: if offset_x and offset_y are both in [4,27] and blink_phase=1 -> 100; otherwise -> 000.
- Coordinates with col>=COLS or row>=ROWS render 000 and issue no RAM read.
- Blink counter: BLINK_LOG2+1 bits, increments on the p_tick where pix_x==0 and pix_y==0. It wraps. blink_phase is the counter MSB.
- Write/clear FSM, one state register:
  - IDLE: clear=1 -> CLEAR with sweep counter=0. Otherwise wr_en=1 with wr_col<COLS and wr_row<ROWS -> write the RAM and pulse wr_ack the next clock; stay in IDLE. Out-of-range writes are dropped with no wr_ack.
  - clear and wr_en asserted together: clear wins and the write is dropped.
  - CLEAR: write 0 to address = counter, one per clock (not tick-gated), busy=1. At counter==COLS*ROWS-1, go to IDLE on the next clock. wr_en and clear are ignored while in CLEAR.
  - Rendering continues during a clear and shows partially cleared contents.
- Reset (any cycle, including mid-sweep):
  - FSM enters CLEAR with counter=0, so the map is cleared after every reset.
  - busy=1 from the first clock after reset.
  - graph_rgb=000, video_on_d=0, wr_ack=0, blink counter=0.
  - Pipeline registers clear to 0.
- Width rules: row*COLS is computed at 9 bits without overflow, maximum address 299.

Decomposition:
- Shared package holds:
  - Cell-code constants CELL_EMPTY/WALL/DIRT/ROBOT.
  - 3-bit colour constants RGB_BLACK/BLUE/YELLOW/RED/WHITE.
  - Grid constants COLS, ROWS, CELL_LOG2.
- One sub-module, tile_map_ram: simple dual-port, 1 write port plus 1 synchronous read port, old-data-on-collision.
- The FSM, pipeline and colour logic stay in the top-level block.

Test Plan:
- Reset pulsed for 1 clock -> busy=1 for exactly 300 clocks then 0. Every cell then reads 0, and every visible pixel of one frame renders 000 except grid lines (111).
- Write col=3, row=2, code=1 while idle -> wr_ack pulse 1 clock later. Pixel (100,70) renders 001 two ticks after it is presented; pixel (96,70) renders 111 (grid line).
- Write code=3 at (0,0); run 64 frames -> pixel (10,10) alternates 100 / 000 every 32 frames; pixel (2,10) is always 000.
- Assert clear and wr_en (col=1, row=1, code=2) in the same clock -> no wr_ack, sweep runs. A write issued mid-sweep is ignored; cell (1,1) reads 0 afterwards.
- Write col=20, row=0 and col=0, row=15 -> no wr_ack; RAM contents unchanged.
- Assert reset at sweep counter=150 of a clear -> sweep restarts at 0; busy stays high a further 300 clocks; outputs are 000 during reset.
